pc_gen: RTL and testbench

- Upstream neighbour of the fetch stage. Owns the architectural fetch PC and drives the instruction-bus request.
- Holds the request address stable until the response returns, and absorbs branch redirects that arrive while a request is in flight by draining and discarding the stale response.
- Buffers one instruction while decode is stalled, and presents registered {valid, pc, instr} to the fetch/decode boundary.

---
 rtl/pc_gen_if.sv | 15 +
 rtl/pc_gen.sv | 146 ++++++++++++++
 tb/tb_pc_gen.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// pc_gen_if: instruction-bus channel between pc_gen and the ibus.
//   ireq_valid    request valid (held until the response returns)
//   ireq_addr     request address, stable while ireq_valid=1
//   iresp_data_ok response valid, one cycle
//   iresp_data    returned instruction word
// master = pc_gen (request side), slave = bus / memory model.
interface pc_gen_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  modport master (output ireq_valid, ireq_addr, input  iresp_data_ok, iresp_data);
  modport slave  (input  ireq_valid, ireq_addr, output iresp_data_ok, iresp_data);
endinterface

// File: rtl/pc_gen.sv
// pc_gen: owns the architectural fetch PC, issues one outstanding ibus request
// at a time, drains stale responses after a redirect, and buffers one
// instruction while decode is stalled.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   stall            downstream hold; out_* frozen except on a redirect flush
//   redirect_valid   single-cycle redirect pulse, target on redirect_pc
//   ibus             pc_gen_if.master instruction-bus channel
//   out_valid/pc/instr  registered instruction presented to decode
//   busy             high in FETCH or DROP (a request is on the bus)
// Optional: define PCGEN_PERF_EN to add perf_drop_cnt / perf_stall_cnt
// (saturating 32-bit counters of discarded responses and HOLD cycles).
module pc_gen #(
  parameter logic [63:0] RESET_PC    = 64'h8000_0000,
  parameter int          INSTR_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  pc_gen_if.master    ibus,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
`ifdef PCGEN_PERF_EN
  output logic [31:0] perf_drop_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {S_FETCH, S_DROP, S_HOLD} state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  localparam logic [63:0] PC_INC = 64'(INSTR_BYTES);

  state_t      state, state_d;
  logic [63:0] pc, pc_d;
  logic [63:0] pend, pend_d;     // redirect target parked while draining
  ent_t        hold, hold_d;     // single-entry stall buffer
  ent_t        out_q, out_d;
  logic        out_vld_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      pend      <= '0;
      hold      <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      pend      <= pend_d;
      hold      <= hold_d;
      out_q     <= out_d;
      out_valid <= out_vld_d;
    end
  end

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    pend_d    = pend;
    hold_d    = hold;
    out_d     = out_q;
    out_vld_d = out_valid;
    case (state)
      S_FETCH: begin
        if (redirect_valid && ibus.iresp_data_ok) begin
          // response belongs to the old path: drop it, refetch at target
          pc_d      = redirect_pc;
          out_vld_d = 1'b0;
        end else if (redirect_valid) begin
          // request still in flight; address must stay put until it lands
          pend_d    = redirect_pc;
          out_vld_d = 1'b0;
          state_d   = S_DROP;
        end else if (ibus.iresp_data_ok) begin
          pc_d = pc + PC_INC;
          if (stall) begin
            hold_d  = '{pc: pc, instr: ibus.iresp_data};
            state_d = S_HOLD;
          end else begin
            out_d     = '{pc: pc, instr: ibus.iresp_data};
            out_vld_d = 1'b1;
          end
        end else if (!stall) begin
          out_vld_d = 1'b0;
        end
      end
      S_DROP: begin
        if (redirect_valid) pend_d = redirect_pc;
        if (ibus.iresp_data_ok) begin
          pc_d    = redirect_valid ? redirect_pc : pend;
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        // PC already points past the buffered instruction
        if (redirect_valid) begin
          hold_d    = '0;
          out_vld_d = 1'b0;
          pc_d      = redirect_pc;
          state_d   = S_FETCH;
        end else if (!stall) begin
          out_d     = hold;
          out_vld_d = 1'b1;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign busy            = (state != S_HOLD);
  assign ibus.ireq_valid = busy;
  assign ibus.ireq_addr  = pc;   // pc only moves on data_ok, so it is stable
  assign out_pc          = out_q.pc;
  assign out_instr       = out_q.instr;

`ifdef PCGEN_PERF_EN
  logic drop_evt;
  assign drop_evt = ibus.iresp_data_ok &&
                    ((state == S_DROP) || (state == S_FETCH && redirect_valid));

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_drop_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (drop_evt && perf_drop_cnt != 32'hFFFF_FFFF)
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
      if (state == S_HOLD && perf_stall_cnt != 32'hFFFF_FFFF)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid, busy;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
`ifdef PCGEN_PERF_EN
  logic [31:0] perf_drop_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  pc_gen_if bus();

  pc_gen #(.RESET_PC(RST_PC), .INSTR_BYTES(4)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ibus(bus),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
`ifdef PCGEN_PERF_EN
    .perf_drop_cnt(perf_drop_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .busy(busy)
  );

  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { bit rv; logic [63:0] addr; bit ov; int drops; int stalls; } cyc_t;

  cyc_t cyc_q[$];   // per-cycle bus/valid expectations
  ent_t ins_q[$];   // instructions expected to reach decode, in order

  int checks = 0, fails = 0;
  bit mon_en = 0;
  bit stall_q = 0;

  // Reference model: a request is outstanding whenever nothing is buffered;
  // a redirect while it is outstanding marks its eventual response stale.
  logic [63:0] m_fetch_pc, m_target;
  bit          m_stale, m_ov;
  ent_t        m_buf[$];
  int          m_drops, m_stalls;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_fetch_pc = RST_PC; m_target = '0; m_stale = 0; m_ov = 0;
    m_buf.delete(); m_drops = 0; m_stalls = 0;
  endfunction

  function automatic void model_step(bit st, bit rd, logic [63:0] rpc, bit dok, logic [31:0] data);
    ent_t e;
    if (m_buf.size() != 0) begin
      m_stalls++;
      if (rd) begin
        m_buf.delete(); m_ov = 0; m_fetch_pc = rpc;
      end else if (!st) begin
        e = m_buf.pop_front(); m_ov = 1; ins_q.push_back(e);
      end
    end else if (m_stale) begin
      if (rd) m_target = rpc;
      if (dok) begin m_fetch_pc = m_target; m_stale = 0; m_drops++; end
    end else if (rd) begin
      m_ov = 0;
      if (dok) begin m_fetch_pc = rpc; m_drops++; end
      else begin m_stale = 1; m_target = rpc; end
    end else if (dok) begin
      e.pc = m_fetch_pc; e.instr = data;
      if (st) m_buf.push_back(e);
      else begin m_ov = 1; ins_q.push_back(e); end
      m_fetch_pc = m_fetch_pc + 64'd4;
    end else if (!st) begin
      m_ov = 0;
    end
  endfunction

  // One clock of stimulus: expectations for this cycle are queued, then the
  // model advances past the upcoming edge.
  task automatic cycle(input bit rst, input bit st, input bit rd, input logic [63:0] rpc,
                       input bit dok, input logic [31:0] data);
    cyc_t c;
    @(posedge clk); #1;
    reset = rst; stall = st; redirect_valid = rd; redirect_pc = rpc;
    bus.iresp_data_ok = dok; bus.iresp_data = data;
    c.rv = (m_buf.size() == 0); c.addr = m_fetch_pc; c.ov = m_ov;
    c.drops = m_drops; c.stalls = m_stalls;
    cyc_q.push_back(c);
    if (rst) model_reset();
    else model_step(st, rd, rpc, dok, data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 0, '0);
  endtask

  // Monitor: compares whatever the DUT presents against the queues.
  always @(negedge clk) begin
    cyc_t c;
    ent_t e;
    if (mon_en) begin
      if (cyc_q.size() != 0) begin
        c = cyc_q.pop_front();
        chk("ireq_valid", 64'(bus.ireq_valid), 64'(c.rv));
        chk("busy", 64'(busy), 64'(c.rv));
        if (c.rv) chk("ireq_addr", bus.ireq_addr, c.addr);
        chk("out_valid", 64'(out_valid), 64'(c.ov));
`ifdef PCGEN_PERF_EN
        chk("perf_drop_cnt", 64'(perf_drop_cnt), 64'(c.drops));
        chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(c.stalls));
`endif
      end
      // out_* can only take a new instruction across an edge where stall was low
      if (out_valid === 1'b1 && !stall_q) begin
        if (ins_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_instr: got pc %h instr %h expected none", out_pc, out_instr);
        end else begin
          e = ins_q.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_instr", 64'(out_instr), 64'(e.instr));
        end
      end
    end
    stall_q = stall;
  end

  initial begin
    bit st, rd, dok;
    logic [63:0] rpc;
    reset = 1; stall = 0; redirect_valid = 0; redirect_pc = '0;
    bus.iresp_data_ok = 0; bus.iresp_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_ireq_valid", 64'(bus.ireq_valid), 64'd1);
    chk("rst_ireq_addr", bus.ireq_addr, RST_PC);
    model_reset();
    mon_en = 1;

    // sequential fetch
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 1, 32'h13);
    // slow bus
    cycle(1, 0, 0, '0, 0, '0);
    cycle(0, 0, 0, '0, 0, '0);
    cycle(0, 0, 0, '0, 0, '0);
    cycle(0, 0, 0, '0, 1, 32'h0000_0093);
    // redirect while in flight, response two cycles later
    cycle(1, 0, 0, '0, 0, '0);
    cycle(0, 0, 1, 64'h8000_1000, 0, '0);
    cycle(0, 0, 0, '0, 0, '0);
    cycle(0, 0, 0, '0, 1, 32'hBAD0_0001);
    cycle(0, 0, 0, '0, 1, 32'h0000_1111);
    // same-cycle redirect + data_ok
    cycle(0, 0, 1, 64'h8000_2000, 1, 32'hBAD0_0002);
    cycle(0, 0, 0, '0, 1, 32'h0000_2222);
    // stall buffering
    cycle(1, 0, 0, '0, 0, '0);
    cycle(0, 1, 0, '0, 1, 32'hDEAD_BEEF);
    cycle(0, 1, 0, '0, 0, '0);
    cycle(0, 1, 0, '0, 0, '0);
    cycle(0, 0, 0, '0, 0, '0);
    cycle(0, 0, 0, '0, 1, 32'h0000_3333);
    // redirect flushes the hold buffer even under stall
    cycle(0, 1, 0, '0, 1, 32'h0000_4444);
    cycle(0, 1, 1, 64'h8000_3000, 0, '0);
    cycle(0, 0, 0, '0, 1, 32'h0000_5555);
    // reset mid-DROP, late data_ok taken as the RESET_PC fetch
    cycle(0, 0, 1, 64'h8000_4000, 0, '0);
    cycle(1, 0, 0, '0, 0, '0);
    cycle(0, 0, 0, '0, 1, 32'h0000_6666);
    // 64-bit wrap of the PC
    cycle(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, '0);
    cycle(0, 0, 0, '0, 1, 32'h0000_7777);
    cycle(0, 0, 0, '0, 1, 32'h0000_8888);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      st  = ($urandom_range(0, 99) < 30);
      rd  = ($urandom_range(0, 99) < 10);
      dok = (m_buf.size() == 0) && ($urandom_range(0, 99) < 50);
      rpc = {32'h8000_0000, $urandom} & ~64'h3;
      if ($urandom_range(0, 49) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF8;
      cycle(($urandom_range(0, 299) == 0), st, rd, rpc, dok, $urandom);
    end
    idle(4);
    @(negedge clk);
    @(negedge clk);
    mon_en = 0;
    chk("ins_q_drained", 64'(ins_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
